csi2_raw10_tx_packetizer: RTL and testbench

- Transmit-side counterpart of the CSI-2 receive path.
- Accepts RAW10 pixels over a valid/ready stream and emits CSI-2 packets for one virtual channel as a 2-lane, 8-bit-per-lane byte stream to the D-PHY TX soft IP.
- Each frame is: Frame Start short packet, LINES long packets (data type 0x2B, with header ECC and CRC-16 footer), Frame End short packet.
- Sits in the byte clock domain in front of the D-PHY TX; sensor emulation and loopback test paths feed it.

---
 rtl/csi2_raw10_tx_packetizer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_csi2_raw10_tx_packetizer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_raw10_tx_packetizer.sv
// CSI-2 RAW10 packetizer: FS, LINES long packets (DT 0x2B, ECC + CRC-16 footer), FE on a 2-lane byte stream.
// Latency: FS word0 is presented (tx_valid_o high) the cycle after frame_start_i is sampled in IDLE.
// Backpressure: words hold while tx_ready_i is low; pixels are taken only while collecting a group (PCOL).
//
// Ports:
//   clk_byte_i, reset_byte_n_i        byte clock, synchronous active-low reset
//   frame_start_i                     starts a frame; honoured only while idle
//   pix_i / pix_valid_i / pix_ready_o RAW10 pixel stream in
//   tx_data_o / tx_valid_o / tx_ready_i  16-bit word out, lane0 = [7:0], lane1 = [15:8]
//   tx_hs_req_o                       high from a packet's first word through its last accepted word
//   busy_o                            high whenever not idle
//   frame_num_o                       frame number of the current or most recent frame
module csi2_raw10_tx_packetizer #(
   parameter int WIDTH      = 8,
   parameter int LINES      = 2,
   parameter int VC         = 0,
   parameter int GAP_CYCLES = 8
) (
   input  logic        clk_byte_i,
   input  logic        reset_byte_n_i,
   input  logic        frame_start_i,
   input  logic [9:0]  pix_i,
   input  logic        pix_valid_i,
   output logic        pix_ready_o,
   output logic [15:0] tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        tx_hs_req_o,
   output logic        busy_o,
   output logic [15:0] frame_num_o
);

   localparam logic [1:0]  VC2       = 2'(VC);
   localparam logic [7:0]  DI_FS     = {VC2, 6'h00};
   localparam logic [7:0]  DI_FE     = {VC2, 6'h01};
   localparam logic [7:0]  DI_LP     = {VC2, 6'h2B};
   localparam logic [15:0] LONG_WC   = 16'(WIDTH * 5 / 4);
   localparam logic [15:0] GRP_LAST  = 16'(WIDTH / 8 - 1);
   localparam logic [15:0] LINE_LAST = 16'(LINES - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FS0, S_FS1, S_GAP, S_LH0, S_LH1,
      S_PCOL, S_PEMIT, S_CRC, S_FE0, S_FE1
   } state_t;

   // Hamming parity masks over {WC_hi, WC_lo, DI}; ECC[5:0] = P5..P0
   function automatic logic [7:0] f_ecc(input logic [23:0] d);
      f_ecc = {2'b00,
               ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
               ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
   endfunction

   // Reflected CRC-16/0x8408, one byte LSB-first
   function automatic logic [15:0] f_crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] x;
      x = c ^ {8'h00, b};
      for (int i = 0; i < 8; i++) begin
         x = x[0] ? ((x >> 1) ^ 16'h8408) : (x >> 1);
      end
      return x;
   endfunction

   // 8 pixels (pixel i at p[i*10 +: 10]) -> 10 bytes (byte k at b[k*8 +: 8])
   function automatic logic [79:0] f_pack(input logic [79:0] p);
      logic [79:0] b;
      b = '0;
      for (int h = 0; h < 2; h++) begin
         for (int j = 0; j < 4; j++) begin
            b[(h*5 + j)*8 +: 8] = p[(h*4 + j)*10 + 2 +: 8];
         end
         b[(h*5 + 4)*8 +: 8] = {p[(h*4 + 3)*10 +: 2], p[(h*4 + 2)*10 +: 2],
                                p[(h*4 + 1)*10 +: 2], p[(h*4)*10 +: 2]};
      end
      return b;
   endfunction

   function automatic logic [15:0] f_hdr_w0(input logic [7:0] di, input logic [15:0] wc);
      return {wc[7:0], di};
   endfunction

   function automatic logic [15:0] f_hdr_w1(input logic [7:0] di, input logic [15:0] wc);
      return {f_ecc({wc, di}), wc[15:8]};
   endfunction

   state_t      r_state;
   state_t      r_after_gap;
   logic [15:0] r_tx_data;
   logic        r_tx_valid;
   logic        r_hs;
   logic        r_busy;
   logic        r_pix_rdy;
   logic [15:0] r_frame_num;
   logic [15:0] r_frame_num_o;
   logic [15:0] r_gap;
   logic [15:0] r_line;
   logic [15:0] r_grp;
   logic [2:0]  r_pix_cnt;
   logic [2:0]  r_widx;
   logic [79:0] r_pix;
   logic [15:0] r_crc;

   logic        w_tx_acc;
   logic        w_pix_acc;
   logic [79:0] w_pix_nxt;
   logic [79:0] w_pk_cur;
   logic [2:0]  w_widx_n;
   logic [15:0] w_crc_upd;

   assign w_tx_acc  = r_tx_valid & tx_ready_i;
   assign w_pix_acc = r_pix_rdy & pix_valid_i;
   assign w_pk_cur  = f_pack(r_pix);
   assign w_widx_n  = r_widx + 3'd1;
   // CRC advanced by the word currently on the bus, lane0 byte first
   assign w_crc_upd = f_crc_byte(f_crc_byte(r_crc, r_tx_data[7:0]), r_tx_data[15:8]);

   always_comb begin
      w_pix_nxt = r_pix;
      w_pix_nxt[r_pix_cnt*10 +: 10] = pix_i;
   end

   always_ff @(posedge clk_byte_i) begin
      if (!reset_byte_n_i) begin
         r_state       <= S_IDLE;
         r_after_gap   <= S_IDLE;
         r_tx_data     <= '0;
         r_tx_valid    <= 1'b0;
         r_hs          <= 1'b0;
         r_busy        <= 1'b0;
         r_pix_rdy     <= 1'b0;
         r_frame_num   <= 16'd1;
         r_frame_num_o <= 16'd1;
         r_gap         <= '0;
         r_line        <= '0;
         r_grp         <= '0;
         r_pix_cnt     <= '0;
         r_widx        <= '0;
         r_pix         <= '0;
         r_crc         <= 16'hFFFF;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (frame_start_i) begin
                  r_state       <= S_FS0;
                  r_tx_data     <= f_hdr_w0(DI_FS, r_frame_num);
                  r_tx_valid    <= 1'b1;
                  r_hs          <= 1'b1;
                  r_busy        <= 1'b1;
                  r_frame_num_o <= r_frame_num;
                  r_line        <= '0;
               end
            end
            S_FS0: begin
               if (w_tx_acc) begin
                  r_state   <= S_FS1;
                  r_tx_data <= f_hdr_w1(DI_FS, r_frame_num);
               end
            end
            S_FS1: begin
               if (w_tx_acc) begin
                  r_state     <= S_GAP;
                  r_tx_valid  <= 1'b0;
                  r_hs        <= 1'b0;
                  r_gap       <= '0;
                  r_after_gap <= S_LH0;
               end
            end
            S_GAP: begin
               // Counted regardless of tx_ready_i; the next packet's first word is loaded on exit
               if (r_gap == GAP_LAST) begin
                  r_gap <= '0;
                  if (r_after_gap == S_LH0) begin
                     r_state    <= S_LH0;
                     r_tx_data  <= f_hdr_w0(DI_LP, LONG_WC);
                     r_tx_valid <= 1'b1;
                     r_hs       <= 1'b1;
                     r_crc      <= 16'hFFFF;
                  end else if (r_after_gap == S_FE0) begin
                     r_state    <= S_FE0;
                     r_tx_data  <= f_hdr_w0(DI_FE, r_frame_num);
                     r_tx_valid <= 1'b1;
                     r_hs       <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_gap <= r_gap + 16'd1;
               end
            end
            S_LH0: begin
               if (w_tx_acc) begin
                  r_state   <= S_LH1;
                  r_tx_data <= f_hdr_w1(DI_LP, LONG_WC);
               end
            end
            S_LH1: begin
               if (w_tx_acc) begin
                  r_state    <= S_PCOL;
                  r_tx_valid <= 1'b0;
                  r_pix_rdy  <= 1'b1;
                  r_pix_cnt  <= '0;
                  r_grp      <= '0;
               end
            end
            S_PCOL: begin
               // tx_valid_o stays low here; tx_hs_req_o stays high so the packet remains open
               if (w_pix_acc) begin
                  r_pix <= w_pix_nxt;
                  if (r_pix_cnt == 3'd7) begin
                     r_state    <= S_PEMIT;
                     r_pix_rdy  <= 1'b0;
                     r_tx_valid <= 1'b1;
                     // word0 only needs P0/P1, which are already held in r_pix
                     r_tx_data  <= w_pk_cur[15:0];
                     r_widx     <= '0;
                  end else begin
                     r_pix_cnt <= r_pix_cnt + 3'd1;
                  end
               end
            end
            S_PEMIT: begin
               if (w_tx_acc) begin
                  r_crc <= w_crc_upd;
                  if (r_widx == 3'd4) begin
                     r_widx <= '0;
                     if (r_grp == GRP_LAST) begin
                        r_state   <= S_CRC;
                        r_tx_data <= w_crc_upd;
                     end else begin
                        r_grp      <= r_grp + 16'd1;
                        r_state    <= S_PCOL;
                        r_tx_valid <= 1'b0;
                        r_pix_rdy  <= 1'b1;
                        r_pix_cnt  <= '0;
                     end
                  end else begin
                     r_widx    <= w_widx_n;
                     r_tx_data <= w_pk_cur[w_widx_n*16 +: 16];
                  end
               end
            end
            S_CRC: begin
               if (w_tx_acc) begin
                  r_state     <= S_GAP;
                  r_tx_valid  <= 1'b0;
                  r_hs        <= 1'b0;
                  r_gap       <= '0;
                  r_after_gap <= (r_line == LINE_LAST) ? S_FE0 : S_LH0;
                  r_line      <= r_line + 16'd1;
               end
            end
            S_FE0: begin
               if (w_tx_acc) begin
                  r_state   <= S_FE1;
                  r_tx_data <= f_hdr_w1(DI_FE, r_frame_num);
               end
            end
            S_FE1: begin
               if (w_tx_acc) begin
                  r_state     <= S_GAP;
                  r_tx_valid  <= 1'b0;
                  r_hs        <= 1'b0;
                  r_gap       <= '0;
                  r_after_gap <= S_IDLE;
                  // 0 is reserved, so the count wraps from 0xFFFF back to 1
                  r_frame_num <= (r_frame_num == 16'hFFFF) ? 16'd1 : r_frame_num + 16'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_data_o   = r_tx_data;
   assign tx_valid_o  = r_tx_valid;
   assign tx_hs_req_o = r_hs;
   assign busy_o      = r_busy;
   assign pix_ready_o = r_pix_rdy;
   assign frame_num_o = r_frame_num_o;

endmodule

// File: tb/tb_csi2_raw10_tx_packetizer.sv
// Bench for csi2_raw10_tx_packetizer: reference frame model feeds a word scoreboard.
// Latency: n/a.
// Backpressure: tx_ready_i and pix_valid_i are randomised per cycle in the later frames.
module tb_csi2_raw10_tx_packetizer;

   localparam int WIDTH = 16;
   localparam int LINES = 2;
   localparam int VC    = 0;
   localparam int GAP   = 5;
   localparam logic [1:0] VCB = 2'(VC);

   // CSI-2 ECC syndrome column for each header data bit D0..D23
   localparam logic [5:0] ECC_COL [0:23] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
   localparam logic [9:0] PAT [0:3] = '{10'h3FF, 10'h000, 10'h155, 10'h2AA};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic [9:0]  pix = '0;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        hs;
   logic        busy;
   logic [15:0] frame_num;

   always #5 clk = ~clk;

   csi2_raw10_tx_packetizer #(
      .WIDTH(WIDTH), .LINES(LINES), .VC(VC), .GAP_CYCLES(GAP)
   ) dut (
      .clk_byte_i    (clk),
      .reset_byte_n_i(rst_n),
      .frame_start_i (frame_start),
      .pix_i         (pix),
      .pix_valid_i   (pix_valid),
      .pix_ready_o   (pix_ready),
      .tx_data_o     (tx_data),
      .tx_valid_o    (tx_valid),
      .tx_ready_i    (tx_ready),
      .tx_hs_req_o   (hs),
      .busy_o        (busy),
      .frame_num_o   (frame_num)
   );

   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] exp_q[$];
   logic [9:0]  pix_q[$];
   bit          rdy_rand = 1'b0;
   bit          pv_rand = 1'b0;
   logic [15:0] m_fnum = 16'd1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] m_ecc(input logic [23:0] d);
      logic [5:0] s = '0;
      for (int i = 0; i < 24; i++) if (d[i]) s = s ^ ECC_COL[i];
      return {2'b00, s};
   endfunction

   // bit-serial reflected CRC-16 (poly 0x1021 reversed), LSB first
   function automatic logic [15:0] m_crc_step(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic push_hdr(input logic [7:0] di, input logic [15:0] wc);
      exp_q.push_back({wc[7:0], di});
      exp_q.push_back({m_ecc({wc, di}), wc[15:8]});
   endtask

   // Builds the whole expected word stream of one frame and the pixels that feed it
   task automatic push_frame(input bit fixed);
      logic [7:0]  lb[$];
      logic [9:0]  g;
      logic [7:0]  lsb;
      logic [15:0] crc;
      push_hdr({VCB, 6'h00}, m_fnum);
      for (int l = 0; l < LINES; l++) begin
         push_hdr({VCB, 6'h2B}, 16'(WIDTH * 5 / 4));
         lb.delete();
         for (int q = 0; q < WIDTH / 4; q++) begin
            lsb = '0;
            for (int j = 0; j < 4; j++) begin
               g = fixed ? PAT[j] : 10'($urandom_range(0, 1023));
               pix_q.push_back(g);
               lb.push_back(g[9:2]);
               lsb[2*j +: 2] = g[1:0];
            end
            lb.push_back(lsb);
         end
         crc = 16'hFFFF;
         for (int k = 0; k < lb.size(); k++) crc = m_crc_step(crc, lb[k]);
         for (int k = 0; k < lb.size() / 2; k++) exp_q.push_back({lb[2*k+1], lb[2*k]});
         exp_q.push_back(crc);
      end
      push_hdr({VCB, 6'h01}, m_fnum);
      m_fnum = (m_fnum == 16'hFFFF) ? 16'd1 : m_fnum + 16'd1;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("wait_idle", busy, 0);
   endtask

   task automatic start_frame(input bit fixed);
      logic [15:0] fn;
      wait_idle(4000);
      @(posedge clk); #1;
      frame_start = 1'b1;
      fn = m_fnum;
      push_frame(fixed);
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(negedge clk);
      check("fs_latency_valid", tx_valid, 1);
      check("fs_word0", tx_data, {fn[7:0], VCB, 6'h00});
      check("busy_in_frame", busy, 1);
      check("frame_num_o", frame_num, fn);
   endtask

   task automatic finish_frame();
      wait_idle(4000);
      check("words_left", exp_q.size(), 0);
      check("pixels_left", pix_q.size(), 0);
   endtask

   task automatic run_frame(input bit fixed, input bit midpulse);
      start_frame(fixed);
      if (midpulse) begin
         repeat (15) @(posedge clk);
         #1 frame_start = 1'b1;
         @(posedge clk); #1;
         frame_start = 1'b0;
      end
      finish_frame();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_valid"}, tx_valid, 0);
      check({tag, "_hs_req"}, hs, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_pix_ready"}, pix_ready, 0);
      check({tag, "_tx_data"}, tx_data, 0);
      check({tag, "_frame_num"}, frame_num, 1);
   endtask

   // Pixel source: drives at negedge; pix_ready_o is registered so it is already final here
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            pix_valid = 1'b0;
         end else if (pix_q.size() > 0 && (!pv_rand || $urandom_range(0, 2) != 0)) begin
            pix       = pix_q[0];
            pix_valid = 1'b1;
            if (pix_ready) void'(pix_q.pop_front());
         end else begin
            pix_valid = 1'b0;
         end
      end
   end

   // Sink + monitor: drives tx_ready and scores every accepted word
   initial begin
      logic        stall;
      logic [15:0] prev;
      logic [15:0] e;
      int          run;
      stall    = 1'b0;
      prev     = '0;
      run      = 0;
      tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            stall = 1'b0;
            run   = 0;
         end else begin
            tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall) begin
               check("hold_valid", tx_valid, 1);
               check("hold_data", tx_data, prev);
            end
            if (tx_valid) begin
               check("hs_with_valid", hs, 1);
               check("pix_ready_low_while_emitting", pix_ready, 0);
            end
            if (tx_valid && tx_ready) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL extra_word: got %h expected no word", tx_data);
               end else begin
                  e = exp_q.pop_front();
                  check("word", tx_data, e);
               end
            end
            stall = tx_valid && !tx_ready;
            prev  = tx_data;
            if (busy && !hs) begin
               run++;
            end else begin
               if (run != 0) check("gap_len", run, GAP);
               run = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int k;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // fixed pixel pattern, no backpressure
      run_frame(1'b1, 1'b0);

      // randomised backpressure and pixel gaps; stray frame_start mid-frame
      rdy_rand = 1'b1;
      pv_rand  = 1'b1;
      run_frame(1'b0, 1'b1);
      run_frame(1'b0, 1'b0);

      // reset in the middle of the payload
      start_frame(1'b0);
      k = 0;
      while (pix_ready !== 1'b1 && k < 500) begin
         @(negedge clk);
         k++;
      end
      check("reach_payload", pix_ready, 1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_q.delete();
      pix_q.delete();
      m_fnum = 16'd1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("mid_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // clean frame after the abort
      run_frame(1'b0, 1'b0);

      // frame counter wrap: 0xFFFF is followed by 1
      @(negedge clk);
      force dut.r_frame_num = 16'hFFFF;
      @(posedge clk); #1;
      release dut.r_frame_num;
      m_fnum = 16'hFFFF;
      run_frame(1'b0, 1'b0);
      run_frame(1'b0, 1'b0);

      repeat (5) @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
